uart_rx_buffered: RTL and testbench
===================================

// Module: uart_rx_buffered
// PURPOSE
// Standalone UART receiver: the far-end counterpart of the Tx_top serial stream.
// Oversamples serial_in on a single clock, deframes start/data/parity/stop, checks parity
// and framing, and buffers good words in a FIFO drained through a valid/ready interface.
// It sits between the external pin and the consumer logic.
// PARAMETERS
// INPUT_DATA_WIDTH  8   data bits per frame, LSB first
// PARITY_ENABLED    1   1: one even-parity bit follows the data; 0: no parity bit
// CLKS_PER_BIT      16  clk cycles per bit period (even, >=4)
// FIFO_DEPTH        4   word entries (power of 2, >=2)
// PORTS
// clk            in   1                        receive clock, rising edge
// reset          in   1                        asynchronous, active-low
// serial_in      in   1                        async serial line, idle high
// o_data         out  INPUT_DATA_WIDTH         FIFO head word
// o_valid        out  1                        FIFO not empty
// i_ready        in   1                        consumer accepts o_data when o_valid&i_ready
// parity_error   out  1                        1-cycle pulse: word dropped, parity mismatch
// framing_error  out  1                        1-cycle pulse: word dropped, stop bit sampled low
// overrun        out  1                        1-cycle pulse: good word dropped, FIFO full
// fifo_count     out  $clog2(FIFO_DEPTH)+1     words held
// BEHAVIOUR
// - Reset values: o_valid=0, o_data=0, all error pulses=0, fifo_count=0, FSM=IDLE.
//   The synchronizer flops reset to 1.
// - Reset asserted mid-frame: frame abandoned, FIFO emptied.
//   After release, wait in IDLE for a falling edge.
// - serial_in passes a 2-flop synchronizer (rx_s). All decisions use rx_s.
// - FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE. One bit counter, one clk counter.
// - IDLE: rx_s 1->0 -> START, counter cleared.
// - START: after CLKS_PER_BIT/2 cycles, sample rx_s. 0 -> DATA. 1 -> IDLE (glitch; no error).
// - DATA: sample every CLKS_PER_BIT cycles and shift in LSB first.
//   After INPUT_DATA_WIDTH samples -> PARITY if PARITY_ENABLED, else STOP.
// - PARITY: sample once. Mismatch is recorded when XOR(data, parity bit) != 0 (even parity).
// - STOP: sample once.
//   - rx_s=0 -> framing_error pulse, word dropped, -> WAIT_IDLE.
//   - Framing error takes priority: parity_error is not pulsed.
//   - rx_s=1 with a parity mismatch -> parity_error pulse, dropped, -> IDLE.
//   - rx_s=1 with good parity -> push word, -> IDLE.
// - WAIT_IDLE: stay until rx_s=1 (break/stuck-low line), then -> IDLE.
//   A line held low never produces a second error.
// - Push occurs on the clock edge of the stop sample.
//   If the FIFO was empty, o_valid=1 and o_data=word on the next cycle.
// - Pop on the edge where o_valid&i_ready. o_data shows the next head on the following cycle.
// - FIFO full with a push and no pop -> overrun pulse, word dropped, contents unchanged.
// - Simultaneous push and pop: both happen and fifo_count is unchanged.
//   This also applies when full (no overrun).
// - Empty FIFO with i_ready=1: no pop, fifo_count stays 0.
// - Read/write pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH.
// - o_data is stable while o_valid=1 and i_ready=0.
// - Each error pulse lasts exactly 1 cycle per offending frame.
// - Receive continues regardless of FIFO state.
// TESTING (CLKS_PER_BIT=16, 8 data bits, parity on; bit period = 16 clk)
// 1. Frame 0xA5 (parity 0, stop 1), i_ready=0 -> o_valid=1, o_data=0xA5, fifo_count=1,
//    no error pulses.
// 2. Frames 0x3C with parity bit 1 -> parity_error pulses once, fifo_count stays 0.
// 3. Frame 0x55 with stop bit 0, then line held low 40 bit periods
//    -> exactly one framing_error pulse. Line high, then frame 0x01 -> 0x01 received.
// 4. 6-cycle low glitch on the idle line -> FSM back to IDLE.
//    No pulse; the next frame 0x7E is received correctly.
// 5. i_ready=0, send 0x01..0x05 -> overrun on the 5th frame, fifo_count=4.
//    Then i_ready=1 -> reads 0x01..0x04 in order.
//    Also: push and pop in the same cycle while full -> no overrun.
// 6. Reset asserted mid-DATA with 2 words buffered -> o_valid=0, fifo_count=0.
//    After release, a clean 0xC3 frame -> 0xC3.

Source files
------------

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver: 2-flop synchronizer, start/data/parity/stop deframer,
// parity and framing checks, and a small FIFO drained through a valid/ready port.
module uart_rx_buffered #(
  parameter int INPUT_DATA_WIDTH = 8,
  parameter int PARITY_ENABLED   = 1,
  parameter int CLKS_PER_BIT     = 16,
  parameter int FIFO_DEPTH       = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          serial_in,
  output logic [INPUT_DATA_WIDTH-1:0]   o_data,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          parity_error,
  output logic                          framing_error,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (INPUT_DATA_WIDTH > 1) ? $clog2(INPUT_DATA_WIDTH) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] HALF_LAST  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(INPUT_DATA_WIDTH - 1);
  localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_PARITY    = 3'd3;
  localparam logic [2:0] S_STOP      = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  logic                        rx_meta, rx_s, rx_prev;
  logic [2:0]                  state;
  logic [CW-1:0]               clk_cnt;
  logic [BW-1:0]               bit_cnt;
  logic [INPUT_DATA_WIDTH-1:0] shift_reg;
  logic                        parity_bad;

  logic [INPUT_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]               wr_ptr, rd_ptr;
  logic                        bit_tick, push, pop, full, wr_en;

  // Synchronizer flops reset to the idle line level so release never fakes a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= serial_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign bit_tick = (clk_cnt == BIT_LAST);
  assign push     = (state == S_STOP) && bit_tick && rx_s && !parity_bad;

  // NOTE: every sequential block uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      parity_bad    <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            state   <= S_START;
            clk_cnt <= '0;
          end
        end
        S_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            parity_bad <= 1'b0;
            state      <= rx_s ? S_IDLE : S_DATA;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (bit_tick) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[INPUT_DATA_WIDTH-1:1]};
            bit_cnt   <= bit_cnt + BW'(1);
            if (bit_cnt == DATA_LAST)
              state <= (PARITY_ENABLED != 0) ? S_PARITY : S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_PARITY: begin
          if (bit_tick) begin
            clk_cnt    <= '0;
            parity_bad <= ^{shift_reg, rx_s};
            state      <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            if (!rx_s) begin
              // Framing wins over parity; the line must go high before re-arming.
              framing_error <= 1'b1;
              state         <= S_WAIT_IDLE;
            end else begin
              parity_error <= parity_bad;
              state        <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end
        S_WAIT_IDLE: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_valid = (fifo_count != '0);
  assign pop     = o_valid && i_ready;
  assign full    = (fifo_count == FULL_COUNT);
  assign wr_en   = push && (!full || pop);

  // NOTE: storage is not reset; o_data is masked while empty, so stale entries never escape.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (wr_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop)   rd_ptr <= rd_ptr + PW'(1);
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + (PW + 1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW + 1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign o_data = o_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: directed scenarios plus randomized frames
// compared against a frame-level reference model (queue of expected words and error counts).
module tb_uart_rx_buffered;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       serial_in;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       parity_error, framing_error, overrun;
  logic [2:0] fifo_count;

  uart_rx_buffered #(
    .INPUT_DATA_WIDTH(8), .PARITY_ENABLED(1), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .serial_in(serial_in),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .parity_error(parity_error), .framing_error(framing_error), .overrun(overrun),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int perr_cnt = 0, ferr_cnt = 0, ovr_cnt = 0;
  int push_lat = 171;
  bit done;
  logic [7:0] rx_q [$];

  // Observation on the falling edge: pulse counts and words actually handed to the consumer.
  always @(negedge clk) begin
    if (parity_error)  perr_cnt++;
    if (framing_error) ferr_cnt++;
    if (overrun)       ovr_cnt++;
    if (o_valid && i_ready) rx_q.push_back(o_data);
  end

  task automatic wait_bit();
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    serial_in = 1'b1;
    repeat (n) wait_bit();
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_parity, input logic stop_bit);
    logic p;
    p = (($countones(d) % 2) != 0) ^ bad_parity;
    serial_in = 1'b0;
    wait_bit();
    for (int i = 0; i < 8; i++) begin
      serial_in = d[i];
      wait_bit();
    end
    serial_in = p;
    wait_bit();
    serial_in = stop_bit;
    wait_bit();
  endtask

  task automatic test_reset();
    reset = 1'b0; serial_in = 1'b1; i_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_tests++;
    if (o_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_data); end
    n_tests++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    n_tests++;
    if ({parity_error, framing_error, overrun} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 000", {parity_error, framing_error, overrun});
    end
    reset = 1'b1;
    idle_bits(2);
  endtask

  task automatic test_single_frame();
    int p0, f0, o0, lat;
    i_ready = 1'b0; rx_q.delete();
    p0 = perr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b0, 1'b1);
      begin
        while (lat < 400) begin
          @(posedge clk);
          #1;
          lat++;
          if (o_valid) break;
        end
      end
    join
    push_lat = lat;
    idle_bits(1);
    n_tests++;
    if (!(lat > 160 && lat <= 176)) begin
      n_fail++; $display("FAIL single_latency: got %0d cycles expected within stop bit 161..176", lat);
    end
    n_tests++;
    if (o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", o_valid); end
    n_tests++;
    if (o_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", o_data); end
    n_tests++;
    if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    n_tests++;
    if ((perr_cnt - p0) + (ferr_cnt - f0) + (ovr_cnt - o0) != 0) begin
      n_fail++; $display("FAIL single_pulses: got %0d pulses expected 0", (perr_cnt - p0) + (ferr_cnt - f0) + (ovr_cnt - o0));
    end
    i_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    i_ready = 1'b0;
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin
      n_fail++; $display("FAIL single_pop: got %0d words expected 1 word a5", rx_q.size());
    end
    n_tests++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL single_drain: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_parity_error();
    int p0, f0;
    i_ready = 1'b0;
    p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'h3C, 1'b1, 1'b1);
    idle_bits(1);
    n_tests++;
    if (perr_cnt - p0 != 1) begin n_fail++; $display("FAIL parity_pulse: got %0d expected 1", perr_cnt - p0); end
    n_tests++;
    if (ferr_cnt - f0 != 0) begin n_fail++; $display("FAIL parity_no_frame: got %0d expected 0", ferr_cnt - f0); end
    n_tests++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL parity_count: got %0d expected 0", fifo_count); end
  endtask

  task automatic test_framing_break();
    int p0, f0;
    i_ready = 1'b1; rx_q.delete();
    p0 = perr_cnt; f0 = ferr_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    repeat (40) wait_bit();
    n_tests++;
    if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL break_frame_pulse: got %0d expected 1", ferr_cnt - f0); end
    n_tests++;
    if (perr_cnt - p0 != 0) begin n_fail++; $display("FAIL break_parity_pulse: got %0d expected 0", perr_cnt - p0); end
    n_tests++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL break_count: got %0d expected 0", fifo_count); end
    idle_bits(2);
    send_frame(8'h01, 1'b0, 1'b1);
    idle_bits(1);
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h01) begin
      n_fail++; $display("FAIL break_recover: got %0d words expected 1 word 01", rx_q.size());
    end
    n_tests++;
    if (ferr_cnt - f0 != 1) begin n_fail++; $display("FAIL break_single_error: got %0d expected 1", ferr_cnt - f0); end
  endtask

  task automatic test_glitch();
    int p0, f0, o0;
    i_ready = 1'b1; rx_q.delete();
    p0 = perr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    serial_in = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    idle_bits(2);
    n_tests++;
    if ((perr_cnt - p0) + (ferr_cnt - f0) + (ovr_cnt - o0) != 0 || rx_q.size() != 0) begin
      n_fail++; $display("FAIL glitch_quiet: got %0d pulses %0d words expected 0 0",
                         (perr_cnt - p0) + (ferr_cnt - f0) + (ovr_cnt - o0), rx_q.size());
    end
    send_frame(8'h7E, 1'b0, 1'b1);
    idle_bits(1);
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'h7E) begin
      n_fail++; $display("FAIL glitch_next_frame: got %0d words expected 1 word 7e", rx_q.size());
    end
  endtask

  task automatic test_overrun();
    int o0, exp_ovr;
    logic [7:0] model_q [$];
    i_ready = 1'b0; rx_q.delete();
    o0 = ovr_cnt; exp_ovr = 0;
    for (int v = 1; v <= 5; v++) begin
      send_frame(8'(v), 1'b0, 1'b1);
      if (model_q.size() < DEPTH) model_q.push_back(8'(v));
      else exp_ovr++;
    end
    idle_bits(1);
    n_tests++;
    if (ovr_cnt - o0 != exp_ovr) begin n_fail++; $display("FAIL overrun_pulse: got %0d expected %0d", ovr_cnt - o0, exp_ovr); end
    n_tests++;
    if (fifo_count !== 3'(DEPTH)) begin n_fail++; $display("FAIL overrun_count: got %0d expected %0d", fifo_count, DEPTH); end
    n_tests++;
    if (o_data !== model_q[0]) begin n_fail++; $display("FAIL overrun_head_stable: got %h expected %h", o_data, model_q[0]); end
    i_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    i_ready = 1'b0;
    n_tests++;
    if (rx_q.size() != model_q.size()) begin
      n_fail++; $display("FAIL overrun_drain_size: got %0d expected %0d", rx_q.size(), model_q.size());
    end else begin
      for (int i = 0; i < model_q.size(); i++) begin
        n_tests++;
        if (rx_q[i] !== model_q[i]) begin n_fail++; $display("FAIL overrun_order[%0d]: got %h expected %h", i, rx_q[i], model_q[i]); end
      end
    end

    // Refill to full, then pop on exactly the edge that pushes a fifth word.
    rx_q.delete(); model_q.delete();
    for (int v = 0; v < DEPTH; v++) begin
      send_frame(8'h11 + 8'(v), 1'b0, 1'b1);
      model_q.push_back(8'h11 + 8'(v));
    end
    o0 = ovr_cnt;
    fork
      send_frame(8'h15, 1'b0, 1'b1);
      begin
        repeat (push_lat - 1) @(posedge clk);
        #1 i_ready = 1'b1;
        @(posedge clk);
        #1 i_ready = 1'b0;
      end
    join
    model_q.push_back(8'h15);
    idle_bits(1);
    n_tests++;
    if (ovr_cnt - o0 != 0) begin n_fail++; $display("FAIL full_pushpop_overrun: got %0d expected 0", ovr_cnt - o0); end
    n_tests++;
    if (fifo_count !== 3'(DEPTH)) begin n_fail++; $display("FAIL full_pushpop_count: got %0d expected %0d", fifo_count, DEPTH); end
    i_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (rx_q.size() != model_q.size()) begin
      n_fail++; $display("FAIL full_pushpop_size: got %0d expected %0d", rx_q.size(), model_q.size());
    end else begin
      for (int i = 0; i < model_q.size(); i++) begin
        n_tests++;
        if (rx_q[i] !== model_q[i]) begin n_fail++; $display("FAIL full_pushpop_order[%0d]: got %h expected %h", i, rx_q[i], model_q[i]); end
      end
    end
    n_tests++;
    if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL empty_ready_count: got %0d expected 0", fifo_count); end
    i_ready = 1'b0;
  endtask

  task automatic test_reset_mid_frame();
    int p0, f0, o0;
    i_ready = 1'b0; rx_q.delete();
    send_frame(8'h21, 1'b0, 1'b1);
    send_frame(8'h42, 1'b0, 1'b1);
    n_tests++;
    if (fifo_count !== 3'd2) begin n_fail++; $display("FAIL midreset_prefill: got %0d expected 2", fifo_count); end
    serial_in = 1'b0; wait_bit();
    serial_in = 1'b1; wait_bit();
    serial_in = 1'b0; wait_bit();
    p0 = perr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (o_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++; $display("FAIL midreset_flush: got valid %b count %0d expected 0 0", o_valid, fifo_count);
    end
    serial_in = 1'b1;
    reset = 1'b1;
    idle_bits(2);
    n_tests++;
    if (fifo_count !== 3'd0 || (perr_cnt - p0) + (ferr_cnt - f0) + (ovr_cnt - o0) != 0) begin
      n_fail++; $display("FAIL midreset_idle: got count %0d pulses %0d expected 0 0",
                         fifo_count, (perr_cnt - p0) + (ferr_cnt - f0) + (ovr_cnt - o0));
    end
    i_ready = 1'b1;
    send_frame(8'hC3, 1'b0, 1'b1);
    idle_bits(1);
    n_tests++;
    if (rx_q.size() != 1 || rx_q[0] !== 8'hC3) begin
      n_fail++; $display("FAIL midreset_next_frame: got %0d words expected 1 word c3", rx_q.size());
    end
  endtask

  task automatic test_random();
    int p0, f0, o0, exp_perr, exp_ferr, kind;
    logic [7:0] d;
    logic [7:0] exp_q [$];
    rx_q.delete();
    p0 = perr_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    exp_perr = 0; exp_ferr = 0;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          d = 8'($urandom);
          kind = $urandom_range(0, 9);
          if (kind == 0) begin
            send_frame(d, 1'b1, 1'b1);
            exp_perr++;
          end else if (kind == 1) begin
            send_frame(d, 1'b0, 1'b0);
            idle_bits(2);
            exp_ferr++;
          end else begin
            send_frame(d, 1'b0, 1'b1);
            exp_q.push_back(d);
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 i_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    n_tests++;
    if (perr_cnt - p0 != exp_perr) begin n_fail++; $display("FAIL random_parity: got %0d expected %0d", perr_cnt - p0, exp_perr); end
    n_tests++;
    if (ferr_cnt - f0 != exp_ferr) begin n_fail++; $display("FAIL random_framing: got %0d expected %0d", ferr_cnt - f0, exp_ferr); end
    n_tests++;
    if (ovr_cnt - o0 != 0) begin n_fail++; $display("FAIL random_overrun: got %0d expected 0", ovr_cnt - o0); end
    n_tests++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL random_word_count: got %0d expected %0d", rx_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_tests++;
        if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_word[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_parity_error();
    test_framing_break();
    test_glitch();
    test_overrun();
    test_reset_mid_frame();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
